// File: rtl/im_stream_reader_if.sv
// Memory read port and pixel stream port of the image stream reader.
// master is the reader side; slave is the memory plus downstream consumer side.
interface im_stream_reader_if #(
  parameter int IM_DATA_W = 8,
  parameter int IM_ADDR_W = 19,
  parameter int ISEL_W    = 2
);
  logic [ISEL_W-1:0]    isel;
  logic                 r_en;
  logic [IM_ADDR_W-1:0] r_addr;
  logic [IM_DATA_W-1:0] r_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [IM_DATA_W-1:0] m_data;
  logic                 m_sof;
  logic                 m_eol;
  logic                 m_eof;

  modport master (
    output isel, r_en, r_addr, m_valid, m_data, m_sof, m_eol, m_eof,
    input  r_data, m_ready
  );

  modport slave (
    input  isel, r_en, r_addr, m_valid, m_data, m_sof, m_eol, m_eof,
    output r_data, m_ready
  );
endinterface

// File: rtl/im_stream_reader.sv
// Reads one image block from memory in raster order and emits it as a pixel stream
// with sof/eol/eof markers; a two-entry FIFO absorbs backpressure at full read rate.
module im_stream_reader #(
  parameter int IM_DATA_W = 8,
  parameter int IM_ADDR_W = 19,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int ISEL_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ISEL_W-1:0]  isel_in,
  output logic               busy,
  output logic               done,
  im_stream_reader_if.master bus
);
  localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [IM_ADDR_W-1:0] LAST_ADDR = IM_ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [X_W-1:0]       X_LAST    = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]       Y_LAST    = Y_W'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state;
  logic [IM_DATA_W-1:0] fifo_mem [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count;
  logic                 pending;
  logic                 pop;
  logic                 issue;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;

  // A read issues only if a FIFO slot is still free once this cycle's pop and arriving data settle;
  // counting the same-cycle pop is what allows one pixel per cycle with only two entries.
  assign pop   = bus.m_valid && bus.m_ready;
  assign issue = (state == RUN) && (count != 2'd2)
                 && (({1'b0, pending} + count - {1'b0, pop}) < 2'd2);

  assign bus.r_en    = issue;
  assign bus.m_valid = (count != 2'd0);
  assign bus.m_data  = fifo_mem[rd_ptr];

  // x/y always describe the FIFO head, because they move only when a pixel transfers.
  assign bus.m_sof = bus.m_valid && (x == '0) && (y == '0);
  assign bus.m_eol = bus.m_valid && (x == X_LAST);
  assign bus.m_eof = bus.m_valid && (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      bus.isel    <= '0;
      bus.r_addr  <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      pending     <= 1'b0;
      x           <= '0;
      y           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            bus.isel   <= isel_in;
            bus.r_addr <= '0;
            x          <= '0;
            y          <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            pending    <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            pending <= 1'b0;
          end else begin
            pending <= issue;
            if (issue) begin
              if (bus.r_addr == LAST_ADDR) state <= DRAIN;
              else bus.r_addr <= bus.r_addr + 1'b1;
            end
            if (pending) begin
              fifo_mem[wr_ptr] <= bus.r_data;
              wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
              rd_ptr <= ~rd_ptr;
              if (x == X_LAST) begin
                x <= '0;
                y <= y + 1'b1;
              end else begin
                x <= x + 1'b1;
              end
              if (bus.m_eof) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
            count <= count + {1'b0, pending} - {1'b0, pop};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
